// File: rtl/owl_frame_pkg.sv
// Shared types and constants for the one-wire-line frame controller.
// TX state encoding, FIFO entry layout and frame-check constants.
package owl_frame_pkg;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_SEND  = 2'd1,
    T_CSUM  = 2'd2,
    T_DRAIN = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } owl_entry_t;

  localparam logic [7:0] CSUM_INIT = 8'h00;
  localparam logic [1:0] MIN_FRAME = 2'd2;

endpackage

// File: rtl/owl_sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit to tell full from empty.
module owl_sync_fifo #(
  parameter int W  = 9,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         do_push, do_pop;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/owl_frame_ctrl.sv
// Frame controller above the one-wire-line byte transceiver: frames host bytes
// with an XOR checksum on TX, and collects received frames with status on RX.
module owl_frame_ctrl
  import owl_frame_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       rx_done,
  output logic       rx_err,
  output logic       tx_busy,
  output logic       owl_wctrl,
  output logic [7:0] owl_wdata,
  input  logic       owl_wflag,
  input  logic       owl_oe,
  output logic       owl_rctrl,
  input  logic [7:0] owl_rdata,
  input  logic       owl_rflag,
  input  logic       owl_rxsof,
  input  logic       owl_rxeof,
  output logic       owl_rx_en
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] FRM_MAX = DEPTH[AW:0];
  localparam logic [AW:0] FRM_ONE = 1;

  // TX FIFO
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [8:0] tx_rdata;
  owl_entry_t tx_head, tx_wentry;

  assign tx_push   = tx_valid & tx_ready;
  assign tx_wentry = '{last: tx_last, data: tx_data};
  assign tx_head   = owl_entry_t'(tx_rdata);

  owl_sync_fifo #(.W(9), .AW(AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tx_wentry),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // RX FIFO
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [8:0] rx_rdata;
  owl_entry_t rx_head, rx_wentry;

  assign rx_pop  = rx_valid & rx_ready;
  assign rx_head = owl_entry_t'(rx_rdata);

  owl_sync_fifo #(.W(9), .AW(AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_wentry),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX state
  tx_state_e   tx_state_q, tx_state_d;
  logic [AW:0] frm_cnt_q, frm_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        gap_q, oe_seen_q, oe_seen_d;
  logic        wr_ok, frm_inc, frm_dec;

  // Whole frames waiting in the TX FIFO; transmission never starts on a partial frame.
  always_comb begin
    frm_inc   = tx_push & tx_last;
    frm_dec   = tx_pop & tx_head.last;
    frm_cnt_d = frm_cnt_q;
    if (frm_inc && !frm_dec && frm_cnt_q != FRM_MAX)
      frm_cnt_d = frm_cnt_q + FRM_ONE;
    else if (frm_dec && !frm_inc && frm_cnt_q != '0)
      frm_cnt_d = frm_cnt_q - FRM_ONE;
  end

  // gap covers the cycle before owl_wflag can reflect the previous strobe.
  always_comb begin
    tx_state_d = tx_state_q;
    csum_d     = csum_q;
    oe_seen_d  = oe_seen_q;
    tx_pop     = 1'b0;
    owl_wctrl  = 1'b0;
    owl_wdata  = 8'h00;
    wr_ok      = ~owl_wflag & ~gap_q;
    case (tx_state_q)
      T_IDLE: begin
        if (frm_cnt_q != '0) begin
          tx_state_d = T_SEND;
          csum_d     = CSUM_INIT;
        end
      end
      T_SEND: begin
        if (wr_ok && !tx_empty) begin
          tx_pop    = 1'b1;
          owl_wctrl = 1'b1;
          owl_wdata = tx_head.data;
          csum_d    = csum_q ^ tx_head.data;
          if (tx_head.last) tx_state_d = T_CSUM;
        end
      end
      T_CSUM: begin
        if (wr_ok) begin
          owl_wctrl  = 1'b1;
          owl_wdata  = csum_q;
          oe_seen_d  = 1'b0;
          tx_state_d = T_DRAIN;
        end
      end
      T_DRAIN: begin
        if (owl_oe) begin
          oe_seen_d = 1'b1;
        end else if (oe_seen_q) begin
          oe_seen_d  = 1'b0;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= T_IDLE;
      frm_cnt_q  <= '0;
      csum_q     <= CSUM_INIT;
      gap_q      <= 1'b0;
      oe_seen_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      frm_cnt_q  <= frm_cnt_d;
      csum_q     <= csum_d;
      gap_q      <= owl_wctrl;
      oe_seen_q  <= oe_seen_d;
    end
  end

  assign tx_ready  = ~tx_full;
  assign tx_busy   = (tx_state_q != T_IDLE);
  assign owl_rx_en = (tx_state_q == T_IDLE) && (frm_cnt_q == '0);

  // RX collector: the newest byte is held back in pend so it can be tagged last at eof.
  logic [7:0] racc_q, racc_d, pend_q, pend_d;
  logic       pend_v_q, pend_v_d, ovf_q, ovf_d;
  logic [1:0] nbytes_q, nbytes_d;
  logic       close_q, close_d, rgap_q, rd_ok;
  logic       rx_done_q, done_d, rx_err_q, err_d;

  always_comb begin
    racc_d    = racc_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    ovf_d     = ovf_q;
    nbytes_d  = nbytes_q;
    close_d   = 1'b0;
    done_d    = 1'b0;
    rx_push   = 1'b0;
    rx_wentry = '0;
    owl_rctrl = 1'b0;
    rd_ok     = owl_rflag & ~rgap_q;

    // Deferred close when eof coincided with a byte that already used the push slot.
    if (close_q) begin
      rx_push   = 1'b1;
      rx_wentry = '{last: 1'b1, data: pend_q};
      pend_v_d  = 1'b0;
      done_d    = 1'b1;
    end
    if (owl_rxsof) begin
      racc_d   = CSUM_INIT;
      pend_v_d = 1'b0;
      ovf_d    = 1'b0;
      nbytes_d = 2'd0;
    end
    if (rd_ok) begin
      owl_rctrl = 1'b1;
      racc_d    = racc_d ^ owl_rdata;
      if (nbytes_d != 2'd3) nbytes_d = nbytes_d + 2'd1;
      if (pend_v_d) begin
        rx_push   = 1'b1;
        rx_wentry = '{last: 1'b0, data: pend_d};
      end
      pend_d   = owl_rdata;
      pend_v_d = 1'b1;
    end
    if (owl_rxeof) begin
      if (rx_push) begin
        close_d = 1'b1;
      end else begin
        if (pend_v_d) begin
          rx_push   = 1'b1;
          rx_wentry = '{last: 1'b1, data: pend_d};
          pend_v_d  = 1'b0;
        end
        done_d = 1'b1;
      end
    end
    if (rx_push && rx_full) ovf_d = 1'b1;
    err_d = done_d & ((racc_d != CSUM_INIT) | ovf_d | (nbytes_d < MIN_FRAME));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      racc_q    <= CSUM_INIT;
      pend_q    <= 8'h00;
      pend_v_q  <= 1'b0;
      ovf_q     <= 1'b0;
      nbytes_q  <= 2'd0;
      close_q   <= 1'b0;
      rgap_q    <= 1'b0;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      racc_q    <= racc_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      ovf_q     <= ovf_d;
      nbytes_q  <= nbytes_d;
      close_q   <= close_d;
      rgap_q    <= owl_rctrl;
      rx_done_q <= done_d;
      rx_err_q  <= err_d;
    end
  end

  assign rx_valid = ~rx_empty;
  assign rx_data  = rx_valid ? rx_head.data : 8'h00;
  assign rx_last  = rx_valid & rx_head.last;
  assign rx_done  = rx_done_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_owl_frame_ctrl.sv
// Scoreboard bench for owl_frame_ctrl: directed frames plus randomized TX/RX
// traffic, with a simple transceiver model driving the owl_* handshake.
module tb_owl_frame_ctrl;

  localparam int AW     = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int BUDGET = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       owl_wflag = 1'b0, owl_oe = 1'b0, owl_rflag = 1'b0;
  logic       owl_rxsof = 1'b0, owl_rxeof = 1'b0;
  logic [7:0] owl_rdata = 8'h00;
  logic       tx_ready, rx_valid, rx_last, rx_done, rx_err, tx_busy;
  logic       owl_wctrl, owl_rctrl, owl_rx_en;
  logic [7:0] rx_data, owl_wdata;

  always #5 clk = ~clk;

  owl_frame_ctrl #(.AW(AW)) dut (
    .rst       (rst),
    .clk       (clk),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_last   (rx_last),
    .rx_ready  (rx_ready),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .tx_busy   (tx_busy),
    .owl_wctrl (owl_wctrl),
    .owl_wdata (owl_wdata),
    .owl_wflag (owl_wflag),
    .owl_oe    (owl_oe),
    .owl_rctrl (owl_rctrl),
    .owl_rdata (owl_rdata),
    .owl_rflag (owl_rflag),
    .owl_rxsof (owl_rxsof),
    .owl_rxeof (owl_rxeof),
    .owl_rx_en (owl_rx_en)
  );

  int         checks = 0;
  int         errors = 0;
  int         strobe_cnt = 0;
  logic [7:0] exp_tx[$];
  logic [8:0] exp_rx[$];
  logic       exp_err[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: transceiver write strobes against the expected byte stream.
  initial begin
    logic prev_busy = 1'b0;
    logic saw_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        saw_oe = 1'b0;
      end else begin
        if (owl_wctrl) begin
          strobe_cnt++;
          check("wflag_low_at_strobe", 32'(owl_wflag), 32'd0);
          if (exp_tx.size() == 0) check("tx_unexpected_strobe", 32'(exp_tx.size()), 32'd1);
          else check("tx_byte", 32'(owl_wdata), 32'(exp_tx.pop_front()));
        end
        if (tx_busy && owl_oe) saw_oe = 1'b1;
        if (prev_busy && !tx_busy) begin
          check("busy_falls_after_oe", 32'({saw_oe, owl_oe}), 32'b10);
          saw_oe = 1'b0;
        end
      end
      prev_busy = tx_busy;
    end
  end

  // Monitor: RX FIFO pops and frame status.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) check("rx_unexpected_entry", 32'(exp_rx.size()), 32'd1);
          else check("rx_entry", 32'({rx_last, rx_data}), 32'(exp_rx.pop_front()));
        end
        if (rx_done) begin
          if (exp_err.size() == 0) check("rx_unexpected_done", 32'(exp_err.size()), 32'd1);
          else check("rx_err", 32'(rx_err), 32'(exp_err.pop_front()));
        end
      end
    end
  end

  // Transceiver TX model: wflag rises one cycle after a strobe and holds a few cycles;
  // oe stays high while bytes are going out and drops after a quiet period.
  initial begin
    logic strobe;
    logic pend_rise = 1'b0;
    int   hold = 0;
    int   idle = 0;
    forever begin
      @(negedge clk);
      strobe = owl_wctrl;
      @(posedge clk);
      #1;
      if (!rst) begin
        owl_wflag = 1'b0; owl_oe = 1'b0; pend_rise = 1'b0; hold = 0; idle = 0;
      end else begin
        if (pend_rise) begin
          owl_wflag = 1'b1;
          hold      = $urandom_range(1, 3);
          pend_rise = 1'b0;
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) owl_wflag = 1'b0;
        end
        if (strobe) begin
          pend_rise = 1'b1;
          owl_oe    = 1'b1;
          idle      = 0;
        end else if (owl_oe && !owl_wflag && !pend_rise) begin
          idle++;
          if (idle >= 6) begin
            owl_oe = 1'b0;
            idle   = 0;
          end
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic tx_push(input logic [7:0] d, input logic last);
    int n = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    while (!tx_ready && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    check("tx_push_wait", 32'(n < BUDGET), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] d[4], input int n);
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(d[i]);
      cs ^= d[i];
      tx_push(d[i], i == n - 1);
    end
    exp_tx.push_back(cs);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tx_busy || !owl_rx_en || exp_tx.size() != 0) && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    check("tx_idle_wait", 32'(n < BUDGET), 32'd1);
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic eof);
    int n = 0;
    owl_rflag = 1'b1; owl_rdata = d;
    #1;
    while (!owl_rctrl && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check("rx_ack_wait", 32'(n < 20), 32'd1);
    owl_rxeof = eof;
    @(posedge clk); #1;
    owl_rxeof = 1'b0;
    @(posedge clk); #1;
    owl_rflag = 1'b0;
  endtask

  // keep = how many bytes the RX FIFO can still absorb; the rest are lost and flag an error.
  task automatic rx_frame(input logic [7:0] d[6], input int n, input logic eof_with_last, input int keep);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) begin
      x ^= d[i];
      if (i < keep) exp_rx.push_back({i == n - 1, d[i]});
    end
    exp_err.push_back((x != 8'h00) || (n < 2) || (n > keep));
    owl_rxsof = 1'b1;
    @(posedge clk); #1;
    owl_rxsof = 1'b0;
    for (int i = 0; i < n; i++) rx_byte(d[i], eof_with_last && (i == n - 1));
    if (!(eof_with_last && n > 0)) begin
      owl_rxeof = 1'b1;
      @(posedge clk); #1;
      owl_rxeof = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] td[4];
    logic [7:0] rd[6];
    int         base, n;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({tx_ready, tx_busy, rx_valid, rx_done, rx_err, owl_wctrl, owl_rctrl, owl_wdata}),
          32'({1'b1, 6'b0, 8'h00}));
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frame: 12, 34 then checksum 26.
    td = '{8'h12, 8'h34, 8'h00, 8'h00};
    tx_frame(td, 2);
    wait_tx_idle();

    // Partial frame holds off transmission; the last byte starts it two cycles later.
    base = strobe_cnt;
    td = '{8'h01, 8'h80, 8'h7E, 8'hC4};
    for (int i = 0; i < 3; i++) begin
      exp_tx.push_back(td[i]);
      tx_push(td[i], 1'b0);
    end
    repeat (8) @(posedge clk);
    #1;
    check("holdoff_no_strobe", 32'(strobe_cnt - base), 32'd0);
    check("holdoff_rx_en", 32'(owl_rx_en), 32'd1);
    exp_tx.push_back(td[3]);
    tx_push(td[3], 1'b1);
    exp_tx.push_back(td[0] ^ td[1] ^ td[2] ^ td[3]);
    @(negedge clk);
    check("latency_cycle1_wctrl", 32'(owl_wctrl), 32'd0);
    @(negedge clk);
    check("latency_cycle2_wctrl", 32'(owl_wctrl), 32'd1);
    @(posedge clk); #1;
    wait_tx_idle();

    // RX good frame, bad checksum, and eof coinciding with the final byte.
    rd = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00};
    rx_frame(rd, 3, 1'b0, 99);
    rd = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    rx_frame(rd, 2, 1'b0, 99);
    rd = '{8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    rx_frame(rd, 2, 1'b1, 99);
    rd = '{8'h10, 8'h22, 8'h32, 8'h00, 8'h00, 8'h00};
    rx_frame(rd, 3, 1'b1, 99);

    // Overflow: host stalls, six bytes arrive, only DEPTH are kept.
    rx_ready = 1'b0;
    rd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx_frame(rd, 6, 1'b0, DEPTH);
    rx_ready = 1'b1;
    n = 0;
    while (exp_rx.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("overflow_drain", 32'(exp_rx.size()), 32'd0);
    @(posedge clk); #1;
    check("overflow_fifo_empty", 32'(rx_valid), 32'd0);

    // Reset while a frame is being sent.
    td = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    base = strobe_cnt;
    tx_frame(td, 4);
    n = 0;
    while (strobe_cnt == base && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("send_started", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("reset_mid_outputs", 32'({tx_ready, tx_busy, owl_wctrl, owl_wdata}), 32'({1'b1, 2'b0, 8'h00}));
    exp_tx.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    base = strobe_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("after_reset_no_strobe", 32'(strobe_cnt - base), 32'd0);
    check("after_reset_state", 32'({owl_rx_en, tx_ready, tx_busy, rx_valid}), 32'b1100);

    // Randomized TX frames, pushed back to back.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 4; i++) td[i] = 8'($urandom);
      tx_frame(td, $urandom_range(1, DEPTH));
    end
    wait_tx_idle();

    // Randomized RX frames: about half carry a correct checksum.
    for (int f = 0; f < 16; f++) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i < 6; i++) rd[i] = 8'($urandom);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        rd[n-1] = 8'h00;
        for (int i = 0; i < n - 1; i++) rd[n-1] ^= rd[i];
      end
      rx_frame(rd, n, 1'($urandom_range(0, 1)), 99);
    end
    repeat (10) @(posedge clk);
    #1;

    check("tx_scoreboard_empty", 32'(exp_tx.size()), 32'd0);
    check("rx_scoreboard_empty", 32'(exp_rx.size()), 32'd0);
    check("err_scoreboard_empty", 32'(exp_err.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
